// File: rtl/booth_mul_pkg.sv
// ============================================================================
// Module      : booth_mul_pkg
// Description : Shared types, constants and round-robin helper for the
//               booth_mul_arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_mul_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int MAX_REQ   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CALC2 = 2'd2,
    RESP  = 2'd3
  } state_e;

  // First asserted valid strictly after ptr, wrapping at n; -1 when none.
  function automatic int rr_winner(input logic [MAX_REQ-1:0] valid,
                                   input int ptr, input int n);
    int         res;
    int         idx;
    logic [3:0] idx4;
    res = -1;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx  = (ptr + k) % n;
      idx4 = 4'(idx);
      if (k <= n && res < 0 && valid[idx4]) begin
        res = idx;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_mul_arbiter_mul.sv
// ============================================================================
// Module      : booth_mul_arbiter_mul
// Description : Combinational radix-4 Booth signed multiplier (WIDTH even).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mul_arbiter_mul
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] pp;
  logic [WIDTH:0]     b_ext;
  logic [2:0]         trip;

  // Partial products are summed modulo 2^(2*WIDTH), so negation is plain two's complement.
  always_comb begin
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    b_ext = {b, 1'b0};
    acc   = '0;
    pp    = '0;
    trip  = '0;
    for (int i = 0; i < WIDTH / 2; i++) begin
      trip = b_ext[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2 * i));
    end
    result = acc;
  end

endmodule

`default_nettype wire

// File: rtl/booth_mul_arbiter.sv
// ============================================================================
// Module      : booth_mul_arbiter
// Description : Round-robin sharing of one signed Booth multiplier between
//               N_REQ requesters with tagged valid/ready responses.
//               Option macro BOOTH_MUL_OUTREG_EN adds an output pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mul_arbiter
  import booth_mul_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]     rsp_result,
  output logic                   busy
);

  state_e             state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [ID_W-1:0]    id_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [2*WIDTH-1:0] rsp_result_q;
`ifdef BOOTH_MUL_OUTREG_EN
  logic [2*WIDTH-1:0] prod_q;
`endif

  logic [MAX_REQ-1:0] valid_ext;
  int                 pick;
  logic               found;
  logic [ID_W-1:0]    win_id;
  logic               grant_ok;
  logic               accept;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = req_valid;
    pick                   = rr_winner(valid_ext, int'(rr_ptr_q), N_REQ);
    found                  = (pick >= 0);
    win_id                 = found ? ID_W'(pick) : '0;
    // A new grant may only overlap the cycle in which the held product leaves.
    grant_ok               = (state_q == IDLE) ||
                             ((state_q == RESP) && rsp_valid_q && rsp_ready);
    accept                 = found && grant_ok;
    req_ready              = '0;
    sel_a                  = '0;
    sel_b                  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        req_ready[i] = accept;
        sel_a        = req_a[i*WIDTH +: WIDTH];
        sel_b        = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  booth_mul_arbiter_mul #(
    .WIDTH  (WIDTH)
  ) u_mul (
    .a      (a_q),
    .b      (b_q),
    .result (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= ID_W'(N_REQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
`ifdef BOOTH_MUL_OUTREG_EN
      prod_q       <= '0;
`endif
    end else begin
      if (accept) begin
        a_q      <= sel_a;
        b_q      <= sel_b;
        id_q     <= win_id;
        rr_ptr_q <= win_id;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= CALC;
        end
`ifdef BOOTH_MUL_OUTREG_EN
        CALC: begin
          prod_q  <= prod;
          state_q <= CALC2;
        end
        CALC2: begin
          rsp_result_q <= prod_q;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
`else
        CALC: begin
          rsp_result_q <= prod;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= accept ? CALC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_booth_mul_arbiter.sv
// ============================================================================
// Module      : tb_booth_mul_arbiter
// Description : Directed scoreboard bench for booth_mul_arbiter (4 requesters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_mul_arbiter;

`ifdef BOOTH_MUL_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] res;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_result;
  logic         busy;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   prev_cyc = 0;
  logic have_prev = 1'b0;
  logic tp_flag = 1'b0;

  booth_mul_arbiter #(.N_REQ(4), .WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [63:0] r);
    exp_t e;
    e.id  = id;
    e.res = r;
    q.push_back(e);
  endtask

  task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  // Each requester drops its valid right after being granted.
  task automatic drain(input int budget);
    int         n;
    logic [3:0] g;
    n = 0;
    while ((req_valid != 4'b0 || q.size() != 0) && n < budget) begin
      @(negedge clk);
      g = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~g;
      n++;
    end
    chk("drain_in_budget", 64'(n < budget), 64'd1);
    repeat (2) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_result", rsp_result, e.res);
      end
      if (tp_flag) begin
        if (have_prev) chk("rsp_interval", 64'(cyc - prev_cyc), 64'(LAT));
        prev_cyc  = cyc;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset values
    do_reset();
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // single request latency
    @(posedge clk); #1;
    drive(0, 32'd50, -32'sd40);
    push(2'd0, 64'hFFFF_FFFF_FFFF_F830);
    @(negedge clk);
    chk("t1_req_ready", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("t1_rsp_valid_timing", 64'(rsp_valid), 64'(k == LAT));
      if (k == 1) chk("t1_busy", 64'(busy), 64'd1);
    end
    drain(20);

    // all four continuously valid: rotation and throughput
    do_reset();
    @(posedge clk); #1;
    have_prev = 1'b0;
    tp_flag   = 1'b1;
    drive(0, 32'd90, 32'd70);
    drive(1, -32'sd80, -32'sd65);
    drive(2, -32'sd10, 32'd325);
    drive(3, -32'sd999, 32'd999);
    push(2'd0, 64'h0000_0000_0000_189C);
    push(2'd1, 64'h0000_0000_0000_1450);
    push(2'd2, 64'hFFFF_FFFF_FFFF_F34E);
    push(2'd3, 64'hFFFF_FFFF_FFF0_C58F);
    drain(60);
    tp_flag = 1'b0;

    // back-pressure in RESP, then same-cycle accept on release
    do_reset();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive(0, 32'd7, -32'sd3);
    drive(1, -32'sd11, 32'd13);
    push(2'd0, 64'hFFFF_FFFF_FFFF_FFEB);
    push(2'd1, 64'hFFFF_FFFF_FFFF_FF71);
    @(negedge clk);
    chk("bp_first_grant", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold_id", 64'(rsp_id), 64'd0);
      chk("bp_hold_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("bp_no_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain(20);

    // arithmetic corners; pointer sits at 1 so order is 2,3,1
    @(posedge clk); #1;
    drive(2, 32'h8000_0000, 32'h8000_0000);
    drive(3, 32'd98756, 32'd0);
    drive(1, 32'd98765, 32'd1);
    push(2'd2, 64'h4000_0000_0000_0000);
    push(2'd3, 64'h0);
    push(2'd1, 64'h0000_0000_0001_81CD);
    drain(40);

    // reset while the product is being computed
    @(posedge clk); #1;
    drive(0, 32'd3, 32'd4);
    @(negedge clk);
    chk("rst_mid_grant", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_result", rsp_result, 64'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(3, -32'sd5, 32'd6);
    drive(0, 32'd12, 32'd12);
    push(2'd0, 64'h0000_0000_0000_0090);
    push(2'd3, 64'hFFFF_FFFF_FFFF_FFE2);
    drain(20);
    chk("final_queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
